// File: rtl/hazard_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl_if
// Brief    : Pipeline-side bundle for the hazard controller: hazard inputs,
//            stall/flush controls, FSM state and event counters.
// Revision : 1.0 - initial release
// ============================================================================
interface hazard_ctrl_if;
    logic        start_i;
    logic        MemRead_EX_i;
    logic [4:0]  RDaddr_EX_i;
    logic [4:0]  RS1addr_ID_i;
    logic [4:0]  RS2addr_ID_i;
    logic        Branch_MEM_i;
    logic        Zero_MEM_i;

    logic        PCWrite_o;
    logic        IF_ID_write_o;
    logic        bubble_ID_EX_o;
    logic        flush_o;
    logic        PCSrc_o;
    logic [1:0]  state_o;
    logic [15:0] stall_cnt_o;
    logic [15:0] flush_cnt_o;

    // Pipeline side: drives hazard information, consumes controls.
    modport master (
        output start_i, MemRead_EX_i, RDaddr_EX_i, RS1addr_ID_i, RS2addr_ID_i,
               Branch_MEM_i, Zero_MEM_i,
        input  PCWrite_o, IF_ID_write_o, bubble_ID_EX_o, flush_o, PCSrc_o,
               state_o, stall_cnt_o, flush_cnt_o
    );

    // Controller side.
    modport slave (
        input  start_i, MemRead_EX_i, RDaddr_EX_i, RS1addr_ID_i, RS2addr_ID_i,
               Branch_MEM_i, Zero_MEM_i,
        output PCWrite_o, IF_ID_write_o, bubble_ID_EX_o, flush_o, PCSrc_o,
               state_o, stall_cnt_o, flush_cnt_o
    );
endinterface
`default_nettype wire

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : hazard_ctrl
// Brief    : Load-use stall and taken-branch flush controller for a 5-stage
//            pipeline, with saturating stall/flush event counters.
// Revision : 1.0 - initial release
// ============================================================================
module hazard_ctrl (
    input  logic         clk_i,
    input  logic         rst_i,
    hazard_ctrl_if.slave bus
);

    localparam logic [1:0]  c_IDLE    = 2'd0;
    localparam logic [1:0]  c_RUN     = 2'd1;
    localparam logic [1:0]  c_STALL   = 2'd2;
    localparam logic [1:0]  c_FLUSH   = 2'd3;
    localparam logic [15:0] c_CNT_MAX = 16'hFFFF;

    logic [1:0]  r_state;
    logic [1:0]  w_next_state;
    logic [15:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;

    logic        w_taken;
    logic        w_rs1_match;
    logic        w_rs2_match;
    logic        w_hazard;
    logic        w_active;
    logic        w_do_flush;
    logic        w_do_stall;

    logic        w_pc_write;
    logic        w_if_id_write;
    logic        w_bubble;
    logic        w_flush;
    logic        w_pc_src;

    // ------------------------------------------------------------------
    // Event decode
    // ------------------------------------------------------------------
    assign w_taken     = bus.Branch_MEM_i & bus.Zero_MEM_i;
    assign w_rs1_match = (bus.RDaddr_EX_i == bus.RS1addr_ID_i);
    assign w_rs2_match = (bus.RDaddr_EX_i == bus.RS2addr_ID_i);

    // x0 is hardwired to zero, so a load into it can never feed a consumer.
    assign w_hazard    = bus.MemRead_EX_i
                       & (bus.RDaddr_EX_i != 5'd0)
                       & (w_rs1_match | w_rs2_match);

    assign w_active    = (r_state != c_IDLE);

    // A taken branch outranks a load-use stall; stalls only start from RUN.
    assign w_do_flush  = w_active & w_taken;
    assign w_do_stall  = (r_state == c_RUN) & ~w_taken & w_hazard;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE: begin
                if (bus.start_i) begin
                    w_next_state = c_RUN;
                end
            end
            c_RUN, c_STALL, c_FLUSH: begin
                if (!bus.start_i) begin
                    w_next_state = c_IDLE;
                end else if (w_do_flush) begin
                    w_next_state = c_FLUSH;
                end else if (w_do_stall) begin
                    w_next_state = c_STALL;
                end else begin
                    w_next_state = c_RUN;
                end
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Output logic: zero-latency decode of state and current inputs
    // ------------------------------------------------------------------
    always_comb begin
        w_pc_write    = 1'b0;
        w_if_id_write = 1'b0;
        w_bubble      = 1'b1;
        w_flush       = 1'b0;
        w_pc_src      = 1'b0;
        if (!rst_i && w_active) begin
            if (w_do_flush) begin
                w_pc_write    = 1'b1;
                w_if_id_write = 1'b1;
                w_bubble      = 1'b0;
                w_flush       = 1'b1;
                w_pc_src      = 1'b1;
            end else if (w_do_stall) begin
                w_pc_write    = 1'b0;
                w_if_id_write = 1'b0;
                w_bubble      = 1'b1;
            end else begin
                w_pc_write    = 1'b1;
                w_if_id_write = 1'b1;
                w_bubble      = 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------
    // Saturating event counters
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_stall_cnt <= 16'd0;
        end else if (w_do_stall && (r_stall_cnt != c_CNT_MAX)) begin
            r_stall_cnt <= r_stall_cnt + 16'd1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_flush_cnt <= 16'd0;
        end else if (w_do_flush && (r_flush_cnt != c_CNT_MAX)) begin
            r_flush_cnt <= r_flush_cnt + 16'd1;
        end
    end

    assign bus.PCWrite_o      = w_pc_write;
    assign bus.IF_ID_write_o  = w_if_id_write;
    assign bus.bubble_ID_EX_o = w_bubble;
    assign bus.flush_o        = w_flush;
    assign bus.PCSrc_o        = w_pc_src;
    assign bus.state_o        = r_state;
    assign bus.stall_cnt_o    = r_stall_cnt;
    assign bus.flush_cnt_o    = r_flush_cnt;

endmodule
`default_nettype wire
